video_timing_gen: RTL and testbench

Parametrised raster timing generator for the DVI/HDMI output path. It replaces the fixed 640x480 counters and sync decode that currently sit in front of the TMDS encoders. It emits a pixel request (coordinates plus valid) a configurable number of cycles ahead of the matching de/hsync/vsync, so colour-generation and encoder latency can be absorbed. It supports arbitrary porch/sync geometry, sync polarity, and a clock-enable pause.

---
 rtl/hdmi_timing_pkg.sv | 35 +++
 rtl/video_timing_gen_if.sv | 22 ++
 rtl/sync_delay_line.sv | 28 ++
 rtl/video_timing_gen.sv | 105 ++++++++++
 tb/tb_video_timing_gen.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared raster timing definitions for the DVI/HDMI output path: standard
// mode geometries and the counter-width helper used by the timing generator.
package hdmi_timing_pkg;

   typedef struct packed {
      int h_active;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_active;
      int v_fp;
      int v_sync;
      int v_bp;
      bit hs_pol;
      bit vs_pol;
   } timing_mode_t;

   localparam timing_mode_t VGA_640x480_60 = '{
      h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
      hs_pol: 1'b0, vs_pol: 1'b0
   };

   localparam timing_mode_t HD_1280x720_60 = '{
      h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
      v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
      hs_pol: 1'b1, vs_pol: 1'b1
   };

   // A counter that must reach n-1 still needs one bit when n is 1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster output bundle: pixel request ahead of the delayed de/hsync/vsync.
interface video_timing_gen_if #(
   parameter int XW = 10,
   parameter int YW = 10
);
   logic          req_valid;
   logic [XW-1:0] req_x;
   logic [YW-1:0] req_y;
   logic          line_start;
   logic          frame_start;
   logic          de;
   logic          hsync;
   logic          vsync;

   modport master (
      output req_valid, req_x, req_y, line_start, frame_start, de, hsync, vsync
   );

   modport slave (
      input req_valid, req_x, req_y, line_start, frame_start, de, hsync, vsync
   );
endinterface

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH shift register that advances only on en, with a selectable
// asynchronous reset value so sync lines can come out of reset deasserted.
module sync_delay_line #(
   parameter int               WIDTH   = 3,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             pixclk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge pixclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: stage-0 pixel request plus
// de/hsync/vsync delayed LEAD enabled cycles to cover colour/encoder latency.
module video_timing_gen
   import hdmi_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA_640x480_60.h_active,
   parameter int H_FP     = VGA_640x480_60.h_fp,
   parameter int H_SYNC   = VGA_640x480_60.h_sync,
   parameter int H_BP     = VGA_640x480_60.h_bp,
   parameter int V_ACTIVE = VGA_640x480_60.v_active,
   parameter int V_FP     = VGA_640x480_60.v_fp,
   parameter int V_SYNC   = VGA_640x480_60.v_sync,
   parameter int V_BP     = VGA_640x480_60.v_bp,
   parameter bit HS_POL   = VGA_640x480_60.hs_pol,
   parameter bit VS_POL   = VGA_640x480_60.vs_pol,
   parameter int LEAD     = 2
) (
   input  logic                pixclk,
   input  logic                rst_n,
   input  logic                en,
   video_timing_gen_if.master  vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int XW      = cnt_width(H_TOTAL);
   localparam int YW      = cnt_width(V_TOTAL);

   localparam int unsigned H_ACT_END = H_ACTIVE;
   localparam int unsigned H_HS_BEG  = H_ACTIVE + H_FP;
   localparam int unsigned H_HS_END  = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned V_ACT_END = V_ACTIVE;
   localparam int unsigned V_VS_BEG  = V_ACTIVE + V_FP;
   localparam int unsigned V_VS_END  = V_ACTIVE + V_FP + V_SYNC;

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
       LEAD < 1 || LEAD > 15) begin : g_cfg_error
      $error("video_timing_gen: geometry widths must be positive and LEAD within 1..15");
   end

   logic [XW-1:0] hcnt, h_next;
   logic [YW-1:0] vcnt, v_next;
   logic          act_next, hs_next, vs_next;
   logic          req_valid_r, line_start_r, frame_start_r;
   logic          hs_lvl, vs_lvl;
   logic [2:0]    dly_out;

   // Next raster position and its flags; computed ahead so every stage-0
   // register describes the same pixel after the edge.
   always_comb begin
      h_next = hcnt + XW'(1);
      v_next = vcnt;
      if (hcnt == XW'(H_TOTAL - 1)) begin
         h_next = '0;
         v_next = (vcnt == YW'(V_TOTAL - 1)) ? '0 : vcnt + YW'(1);
      end
      act_next = (32'(h_next) < H_ACT_END) && (32'(v_next) < V_ACT_END);
      hs_next  = (32'(h_next) >= H_HS_BEG) && (32'(h_next) < H_HS_END);
      vs_next  = (32'(v_next) >= V_VS_BEG) && (32'(v_next) < V_VS_END);
   end

   always_ff @(posedge pixclk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt          <= XW'(H_TOTAL - 1);
         vcnt          <= YW'(V_TOTAL - 1);
         req_valid_r   <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         hs_lvl        <= ~HS_POL;
         vs_lvl        <= ~VS_POL;
      end else if (en) begin
         hcnt          <= h_next;
         vcnt          <= v_next;
         req_valid_r   <= act_next;
         line_start_r  <= (h_next == '0);
         frame_start_r <= (h_next == '0) && (v_next == '0);
         hs_lvl        <= hs_next ? HS_POL : ~HS_POL;
         vs_lvl        <= vs_next ? VS_POL : ~VS_POL;
      end
   end

   // Sync levels already carry their polarity, so reset leaves them idle.
   sync_delay_line #(
      .WIDTH   (3),
      .DEPTH   (LEAD),
      .RST_VAL ({1'b0, ~HS_POL, ~VS_POL})
   ) u_sync_delay (
      .pixclk (pixclk),
      .rst_n  (rst_n),
      .en     (en),
      .din    ({req_valid_r, hs_lvl, vs_lvl}),
      .dout   (dly_out)
   );

   assign vid.req_valid   = req_valid_r;
   assign vid.req_x       = hcnt;
   assign vid.req_y       = vcnt;
   assign vid.line_start  = line_start_r;
   assign vid.frame_start = frame_start_r;
   assign vid.de          = dly_out[2];
   assign vid.hsync       = dly_out[1];
   assign vid.vsync       = dly_out[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a reference raster model feeds a queue of
// delayed sync levels that is popped and compared as the DUTs produce them.
module tb_video_timing_gen;
   import hdmi_timing_pkg::*;

   typedef struct packed {
      int ha; int hf; int hs; int hb;
      int va; int vf; int vs; int vb;
      bit hp; bit vp;
   } geom_t;

   // DUT A keeps the 640-wide line but a short frame so two frames stay cheap.
   localparam geom_t GA = '{ha: 640, hf: 16, hs: 96, hb: 48,
                            va: 8, vf: 2, vs: 2, vb: 3, hp: 1'b0, vp: 1'b0};
   localparam geom_t GB = '{ha: 4, hf: 1, hs: 2, hb: 1,
                            va: 3, vf: 1, vs: 1, vb: 1, hp: 1'b1, vp: 1'b1};
   localparam int A_LEAD = 2;
   localparam int B_LEAD = 1;
   localparam int A_HT = 800;
   localparam int A_VT = 15;
   localparam int B_HT = 8;
   localparam int B_VT = 6;
   localparam int A_XW = cnt_width(A_HT);
   localparam int A_YW = cnt_width(A_VT);
   localparam int B_XW = cnt_width(B_HT);
   localparam int B_YW = cnt_width(B_VT);

   logic pixclk = 1'b0;
   logic rstA, rstB, enA, enB;
   int   vectors, miscompares;

   always #5 pixclk = ~pixclk;

   video_timing_gen_if #(.XW(A_XW), .YW(A_YW)) ifA ();
   video_timing_gen_if #(.XW(B_XW), .YW(B_YW)) ifB ();

   video_timing_gen #(
      .H_ACTIVE(GA.ha), .H_FP(GA.hf), .H_SYNC(GA.hs), .H_BP(GA.hb),
      .V_ACTIVE(GA.va), .V_FP(GA.vf), .V_SYNC(GA.vs), .V_BP(GA.vb),
      .HS_POL(GA.hp), .VS_POL(GA.vp), .LEAD(A_LEAD)
   ) dutA (.pixclk(pixclk), .rst_n(rstA), .en(enA), .vid(ifA));

   video_timing_gen #(
      .H_ACTIVE(GB.ha), .H_FP(GB.hf), .H_SYNC(GB.hs), .H_BP(GB.hb),
      .V_ACTIVE(GB.va), .V_FP(GB.vf), .V_SYNC(GB.vs), .V_BP(GB.vb),
      .HS_POL(GB.hp), .VS_POL(GB.vp), .LEAD(B_LEAD)
   ) dutB (.pixclk(pixclk), .rst_n(rstB), .en(enB), .vid(ifB));

   // Reference flags for a pixel: {active, line_start, frame_start, hs level, vs level}.
   function automatic logic [4:0] pixFlags(input geom_t g, input int x, input int y);
      logic act, hsA, vsA;
      act = (x < g.ha) && (y < g.va);
      hsA = (x >= g.ha + g.hf) && (x < g.ha + g.hf + g.hs);
      vsA = (y >= g.va + g.vf) && (y < g.va + g.vf + g.vs);
      return {act, x == 0, (x == 0) && (y == 0), hsA ? g.hp : ~g.hp, vsA ? g.vp : ~g.vp};
   endfunction

   int         ax, ay, bx, by;
   logic       aRv, aLs, aFs, bRv, bLs, bFs;
   logic [2:0] aOut, bOut;
   logic [2:0] aQ[$];
   logic [2:0] bQ[$];

   task automatic modelResetA();
      ax = A_HT - 1; ay = A_VT - 1;
      aRv = 1'b0; aLs = 1'b0; aFs = 1'b0;
      aQ.delete();
      for (int i = 0; i < A_LEAD; i++) aQ.push_back({1'b0, ~GA.hp, ~GA.vp});
      aOut = {1'b0, ~GA.hp, ~GA.vp};
   endtask

   task automatic modelStepA();
      logic [4:0] f;
      if (ax == A_HT - 1) begin
         ax = 0;
         ay = (ay == A_VT - 1) ? 0 : ay + 1;
      end else begin
         ax++;
      end
      f = pixFlags(GA, ax, ay);
      {aRv, aLs, aFs} = f[4:2];
      aQ.push_back({f[4], f[1:0]});
      aOut = aQ.pop_front();
   endtask

   task automatic modelResetB();
      bx = B_HT - 1; by = B_VT - 1;
      bRv = 1'b0; bLs = 1'b0; bFs = 1'b0;
      bQ.delete();
      for (int i = 0; i < B_LEAD; i++) bQ.push_back({1'b0, ~GB.hp, ~GB.vp});
      bOut = {1'b0, ~GB.hp, ~GB.vp};
   endtask

   task automatic modelStepB();
      logic [4:0] f;
      if (bx == B_HT - 1) begin
         bx = 0;
         by = (by == B_VT - 1) ? 0 : by + 1;
      end else begin
         bx++;
      end
      f = pixFlags(GB, bx, by);
      {bRv, bLs, bFs} = f[4:2];
      bQ.push_back({f[4], f[1:0]});
      bOut = bQ.pop_front();
   endtask

   function automatic logic [31:0] obsA();
      return 32'({ifA.req_valid, ifA.req_x, ifA.req_y, ifA.line_start,
                  ifA.frame_start, ifA.de, ifA.hsync, ifA.vsync});
   endfunction

   function automatic logic [31:0] expA();
      return 32'({aRv, A_XW'(ax), A_YW'(ay), aLs, aFs, aOut});
   endfunction

   function automatic logic [31:0] obsB();
      return 32'({ifB.req_valid, ifB.req_x, ifB.req_y, ifB.line_start,
                  ifB.frame_start, ifB.de, ifB.hsync, ifB.vsync});
   endfunction

   function automatic logic [31:0] expB();
      return 32'({bRv, B_XW'(bx), B_YW'(by), bLs, bFs, bOut});
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Inputs change on the falling edge; the model advances for the coming rising edge.
   task automatic applyStimulus(input bit eA, input bit eB);
      enA = eA;
      enB = eB;
      if (eA && rstA) modelStepA();
      if (eB && rstB) modelStepB();
      @(negedge pixclk);
   endtask

   task automatic checkOutputs();
      checkOutput("rasterA", obsA(), expA());
      checkOutput("rasterB", obsB(), expB());
   endtask

   task automatic cycle(input bit eA, input bit eB);
      applyStimulus(eA, eB);
      checkOutputs();
   endtask

   initial begin
      int   lastFs, rvCnt, lsCnt, hsLow, vsLow, deCnt, guard;
      int   lastFsB, hsHighB, vsHighB, prevBx, prevBy;
      logic prevHs, prevDe, prevVs;

      vectors = 0; miscompares = 0;
      rstA = 1'b0; rstB = 1'b0; enA = 1'b0; enB = 1'b0;
      modelResetA();
      modelResetB();
      @(negedge pixclk);
      @(negedge pixclk);
      checkOutputs();
      checkOutput("rst_valid", 32'(ifA.req_valid), 0);
      checkOutput("rst_de",    32'(ifA.de), 0);
      checkOutput("rst_hsync", 32'(ifA.hsync), 1);
      checkOutput("rst_vsync", 32'(ifA.vsync), 1);

      $display("[TB] DUT A: first frame after reset, then mid-frame reset");
      rstA = 1'b1;
      cycle(1, 0);
      checkOutput("first_x",  32'(ifA.req_x), 0);
      checkOutput("first_y",  32'(ifA.req_y), 0);
      checkOutput("first_fs", 32'(ifA.frame_start), 1);
      repeat (1000) cycle(1, 0);
      #3 rstA = 1'b0;
      modelResetA();
      @(negedge pixclk);
      checkOutputs();
      checkOutput("midrst_valid", 32'(ifA.req_valid), 0);
      checkOutput("midrst_de",    32'(ifA.de), 0);
      checkOutput("midrst_hsync", 32'(ifA.hsync), 1);
      checkOutput("midrst_vsync", 32'(ifA.vsync), 1);
      repeat (2) cycle(1, 0);
      rstA = 1'b1;

      $display("[TB] DUT A: two full frames with edge and per-frame checks");
      lastFs = -1; rvCnt = 0; lsCnt = 0; hsLow = 0; vsLow = 0; deCnt = 0;
      prevHs = 1'b1; prevDe = 1'b0; prevVs = 1'b1;
      for (int c = 0; c < 2 * A_HT * A_VT + 1; c++) begin
         cycle(1, 0);
         if (ifA.frame_start) begin
            if (lastFs >= 0) begin
               checkOutput("frame_period",        c - lastFs, A_HT * A_VT);
               checkOutput("valid_per_frame",     rvCnt, GA.ha * GA.va);
               checkOutput("lines_per_frame",     lsCnt, A_VT);
               checkOutput("hsync_low_per_frame", hsLow, GA.hs * A_VT);
               checkOutput("vsync_low_per_frame", vsLow, GA.vs * A_HT);
               checkOutput("de_per_frame",        deCnt, GA.ha * GA.va);
            end
            lastFs = c; rvCnt = 0; lsCnt = 0; hsLow = 0; vsLow = 0; deCnt = 0;
         end
         if (ifA.req_valid)  rvCnt++;
         if (ifA.line_start) lsCnt++;
         if (!ifA.hsync)     hsLow++;
         if (!ifA.vsync)     vsLow++;
         if (ifA.de)         deCnt++;
         if (prevHs && !ifA.hsync)
            checkOutput("hs_fall_x", 32'(ifA.req_x), GA.ha + GA.hf + A_LEAD);
         if (!prevHs && ifA.hsync)
            checkOutput("hs_rise_x", 32'(ifA.req_x), GA.ha + GA.hf + GA.hs + A_LEAD);
         if (prevDe && !ifA.de)
            checkOutput("de_fall_x", 32'(ifA.req_x), GA.ha + A_LEAD);
         if (prevVs && !ifA.vsync) begin
            checkOutput("vs_fall_x", 32'(ifA.req_x), A_LEAD);
            checkOutput("vs_fall_y", 32'(ifA.req_y), GA.va + GA.vf);
         end
         if (!prevVs && ifA.vsync) begin
            checkOutput("vs_rise_x", 32'(ifA.req_x), A_LEAD);
            checkOutput("vs_rise_y", 32'(ifA.req_y), GA.va + GA.vf + GA.vs);
         end
         prevHs = ifA.hsync; prevDe = ifA.de; prevVs = ifA.vsync;
      end

      $display("[TB] DUT A: enable pause at req_x=100");
      guard = 0;
      while (ifA.req_x != A_XW'(100) && guard < 2 * A_HT) begin
         cycle(1, 0);
         guard++;
      end
      checkOutput("pause_reach_x", 32'(ifA.req_x), 100);
      repeat (5) cycle(0, 0);
      cycle(1, 0);
      checkOutput("resume_x", 32'(ifA.req_x), 101);
      repeat (2 * A_HT) cycle(1, 0);

      $display("[TB] DUT B: small geometry, positive syncs, LEAD=1");
      rstB = 1'b1;
      cycle(0, 1);
      checkOutput("b_first_x",  32'(ifB.req_x), 0);
      checkOutput("b_first_y",  32'(ifB.req_y), 0);
      checkOutput("b_first_fs", 32'(ifB.frame_start), 1);
      lastFsB = 0; hsHighB = 0; vsHighB = 0;
      if (ifB.hsync) hsHighB++;
      if (ifB.vsync) vsHighB++;
      prevBx = int'(ifB.req_x); prevBy = int'(ifB.req_y);
      for (int c = 1; c < 2 * B_HT * B_VT + 1; c++) begin
         cycle(0, 1);
         if (prevBx == B_HT - 1) checkOutput("b_x_wrap", 32'(ifB.req_x), 0);
         if (prevBy == B_VT - 1 && int'(ifB.req_y) != prevBy)
            checkOutput("b_y_wrap", 32'(ifB.req_y), 0);
         if (ifB.frame_start) begin
            checkOutput("b_frame_period",     c - lastFsB, B_HT * B_VT);
            checkOutput("b_hsync_high_frame", hsHighB, GB.hs * B_VT);
            checkOutput("b_vsync_high_frame", vsHighB, GB.vs * B_HT);
            lastFsB = c; hsHighB = 0; vsHighB = 0;
         end
         if (ifB.hsync) hsHighB++;
         if (ifB.vsync) vsHighB++;
         prevBx = int'(ifB.req_x); prevBy = int'(ifB.req_y);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
